// File: rtl/rsa_axil_regbank.sv
// AXI4-Lite register bank for the RSA core: NUM_RW control registers plus NUM_RO status registers.
// Define RSA_REGBANK_SLVERR_EN to return SLVERR for RO/unmapped writes and unmapped reads.
module rsa_axil_regbank #(
  parameter int                      C_DATA_WIDTH = 32,
  parameter int                      C_ADDR_WIDTH = 8,
  parameter int                      NUM_RW       = 8,
  parameter int                      NUM_RO       = 4,
  parameter logic [C_DATA_WIDTH-1:0] RW_RESET     = '0
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [NUM_RW*C_DATA_WIDTH-1:0]   rw_regs,
  output logic [NUM_RW-1:0]                wr_pulse,
  input  logic [NUM_RO*C_DATA_WIDTH-1:0]   ro_in
);
  localparam int W    = C_DATA_WIDTH;
  localparam int NB   = W / 8;
  localparam int ALSB = (W == 64) ? 3 : 2;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e                 wstate_q;
  rstate_e                 rstate_q;
  logic                    en_q;
  logic                    aw_held_q, w_held_q;
  logic [C_ADDR_WIDTH-1:0] awaddr_q;
  logic [W-1:0]            wdata_q;
  logic [NB-1:0]           wstrb_q;
  logic                    bvalid_q, rvalid_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [W-1:0]            rdata_q;
  logic [NUM_RW-1:0][W-1:0] regs_q, regs_d;
  logic [NUM_RW-1:0]       pulse_q, pulse_d;

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [C_ADDR_WIDTH-1:0] aw_addr_eff;
  logic [W-1:0]            wdata_eff;
  logic [NB-1:0]           wstrb_eff;
  logic [31:0]             w_idx, ar_idx;
  logic                    w_bad, rd_unmapped;
  logic [W-1:0]            rd_data;
  logic [1:0]              wr_resp, rd_resp;

  // en_q keeps every READY low while reset is asserted and for the first cycle after.
  assign S_AXI_AWREADY = en_q && (wstate_q == W_IDLE) && !aw_held_q;
  assign S_AXI_WREADY  = en_q && (wstate_q == W_IDLE) && !w_held_q;
  assign S_AXI_ARREADY = en_q && (rstate_q == R_IDLE);
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign rw_regs       = regs_q;
  assign wr_pulse      = pulse_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A channel arriving this cycle is used directly so the commit lands on its handshake edge.
  assign aw_addr_eff = aw_held_q ? awaddr_q : S_AXI_AWADDR;
  assign wdata_eff   = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wstrb_eff   = w_held_q ? wstrb_q : S_AXI_WSTRB;
  assign commit      = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign w_idx       = 32'(aw_addr_eff[C_ADDR_WIDTH-1:ALSB]);
  assign ar_idx      = 32'(S_AXI_ARADDR[C_ADDR_WIDTH-1:ALSB]);
  assign w_bad       = w_idx >= NUM_RW;
  assign rd_unmapped = ar_idx >= (NUM_RW + NUM_RO);

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (commit) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (w_idx == i) begin
          pulse_d[i] = 1'b1;
          for (int b = 0; b < NB; b++)
            if (wstrb_eff[b]) regs_d[i][b*8 +: 8] = wdata_eff[b*8 +: 8];
        end
      end
    end
  end

  // Reads sample regs_q, so a same-edge write is seen only by the next read.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (ar_idx == i) rd_data = regs_q[i];
    for (int j = 0; j < NUM_RO; j++)
      if (ar_idx == NUM_RW + j) rd_data = ro_in[j*W +: W];
  end

`ifdef RSA_REGBANK_SLVERR_EN
  assign wr_resp = w_bad ? 2'b10 : 2'b00;
  assign rd_resp = rd_unmapped ? 2'b10 : 2'b00;
`else
  logic unused_err;
  assign wr_resp    = 2'b00;
  assign rd_resp    = 2'b00;
  assign unused_err = w_bad | rd_unmapped;
`endif

  logic unused_in;
  assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_eff[ALSB-1:0], S_AXI_ARADDR[ALSB-1:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      en_q      <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      regs_q    <= {NUM_RW{RW_RESET}};
      pulse_q   <= '0;
    end else begin
      en_q    <= 1'b1;
      regs_q  <= regs_d;
      pulse_q <= pulse_d;

      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            awaddr_q  <= S_AXI_AWADDR;
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
          end
          if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
            wstate_q  <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            wstate_q <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase

      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
            rvalid_q <= 1'b1;
            rstate_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            rstate_q <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_axil_regbank.sv
// Scoreboard bench for rsa_axil_regbank: stimulus pushes expected B/R/wr_pulse events, a monitor pops them.
module tb_rsa_axil_regbank;
  localparam int NUM_RW = 8;
  localparam int NUM_RO = 4;
  localparam logic [1:0] OK = 2'b00;
`ifdef RSA_REGBANK_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic              clk = 1'b0;
  logic              ARESETN;
  logic [7:0]        S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]        S_AXI_AWPROT, S_AXI_ARPROT;
  logic              S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP, S_AXI_RRESP;
  logic              S_AXI_BVALID, S_AXI_BREADY;
  logic              S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic              S_AXI_RVALID, S_AXI_RREADY;
  logic [NUM_RW*32-1:0] rw_regs;
  logic [NUM_RW-1:0]    wr_pulse;
  logic [NUM_RO*32-1:0] ro_in;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [7:0]  pq[$];

  always #5 clk = ~clk;

  rsa_axil_regbank dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .rw_regs(rw_regs), .wr_pulse(wr_pulse), .ro_in(ro_in)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Handshakes complete on the posedge after the negedge that sees VALID && READY.
  always @(negedge clk) begin
    if (ARESETN) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", {62'd0, S_AXI_BRESP}, {62'd0, bq.pop_front()});
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else chk("rdata_rresp", {30'd0, S_AXI_RDATA, S_AXI_RRESP}, {30'd0, rq.pop_front()});
      end
      if (wr_pulse != '0) begin
        if (pq.size() == 0) chk("pulse_unexpected", {56'd0, wr_pulse}, 0);
        else chk("wr_pulse", {56'd0, wr_pulse}, {56'd0, pq.pop_front()});
      end
    end
  end

  // Caller sits just after a posedge with addr/data already driven.
  task automatic hs(input bit aw, input bit w, input bit ar, output int cyc);
    bit da, dw, dr;
    da = !aw; dw = !w; dr = !ar; cyc = 0;
    S_AXI_AWVALID = aw; S_AXI_WVALID = w; S_AXI_ARVALID = ar;
    while (!(da && dw && dr) && cyc < 20) begin
      @(negedge clk);
      if (S_AXI_AWVALID && S_AXI_AWREADY) da = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) dw = 1;
      if (S_AXI_ARVALID && S_AXI_ARREADY) dr = 1;
      @(posedge clk); #1;
      if (da) S_AXI_AWVALID = 0;
      if (dw) S_AXI_WVALID = 0;
      if (dr) S_AXI_ARVALID = 0;
      cyc++;
    end
    if (!(da && dw && dr)) begin
      chk("hs_timeout", 0, 1);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    end
  endtask

  task automatic wait_b();
    int n = 0;
    @(negedge clk);
    while (!S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
    if (!S_AXI_BVALID) chk("b_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_r();
    int n = 0;
    @(negedge clk);
    while (!S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
    if (!S_AXI_RVALID) chk("r_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [7:0] pulse, input logic [1:0] resp);
    int c;
    bq.push_back(resp);
    if (pulse != 0) pq.push_back(pulse);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    hs(1, 1, 0, c);
    wait_b();
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] resp);
    int c;
    rq.push_back({d, resp});
    S_AXI_ARADDR = a;
    hs(0, 0, 1, c);
    wait_r();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cyc;
    ARESETN = 0;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 1; S_AXI_ARADDR = 0; S_AXI_ARPROT = 0;
    S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    ro_in = '0;
    ro_in[31:0]   = 32'hDEADBEEF;
    ro_in[127:96] = 32'h12345678;

    #50;
    chk("reset_ctrl", {58'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, 1'b0}, 0);
    chk("reset_resp_data", {26'd0, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP, wr_pulse}, 0);
    chk("reset_rw_regs", {63'd0, |rw_regs}, 0);
    #50 ARESETN = 1;
    @(posedge clk); #1;

    // Basic writes and read-back
    for (int i = 0; i < 4; i++)
      do_write(8'(i*4), 32'(i+1), 4'hF, 8'(1 << i), OK);
    for (int i = 0; i < 4; i++)
      do_read(8'(i*4), 32'(i+1), OK);

    // Byte strobes, then an all-zero strobe that still pulses
    do_write(8'h04, 32'hAABBCCDD, 4'hF, 8'h02, OK);
    do_write(8'h04, 32'h11223344, 4'b0101, 8'h02, OK);
    do_read(8'h04, 32'hAA22CC44, OK);
    do_write(8'h04, 32'hFFFFFFFF, 4'h0, 8'h02, OK);
    do_read(8'h04, 32'hAA22CC44, OK);

    // Last RW register, low address bits ignored
    do_write(8'h1C, 32'h77, 4'hF, 8'h80, OK);
    do_read(8'h1F, 32'h77, OK);

    // W three cycles ahead of AW, with BREADY backpressure
    S_AXI_WDATA = 32'hA5; S_AXI_WSTRB = 4'hF; S_AXI_AWADDR = 8'h10;
    bq.push_back(OK); pq.push_back(8'h10);
    S_AXI_BREADY = 0;
    hs(0, 1, 0, cyc);
    repeat (3) begin @(negedge clk); chk("bvalid_w_only", {63'd0, S_AXI_BVALID}, 0); end
    @(posedge clk); #1;
    hs(1, 0, 0, cyc);
    @(negedge clk); chk("bvalid_lat_w_first", {63'd0, S_AXI_BVALID}, 1);
    repeat (5) begin @(negedge clk); chk("b_hold", {61'd0, S_AXI_BVALID, S_AXI_BRESP}, {61'd0, 1'b1, OK}); end
    @(posedge clk); #1; S_AXI_BREADY = 1;
    @(posedge clk); #1;
    @(negedge clk); chk("bvalid_cleared", {63'd0, S_AXI_BVALID}, 0);
    @(posedge clk); #1;

    // AW two cycles ahead of W
    S_AXI_AWADDR = 8'h14; S_AXI_WDATA = 32'h5A;
    bq.push_back(OK); pq.push_back(8'h20);
    hs(1, 0, 0, cyc);
    repeat (2) begin @(negedge clk); chk("bvalid_aw_only", {63'd0, S_AXI_BVALID}, 0); end
    @(posedge clk); #1;
    hs(0, 1, 0, cyc);
    @(negedge clk); chk("bvalid_lat_aw_first", {63'd0, S_AXI_BVALID}, 1);
    @(posedge clk); #1;
    do_read(8'h10, 32'hA5, OK);
    do_read(8'h14, 32'h5A, OK);

    // Read-only and unmapped space
    do_read(8'h20, 32'hDEADBEEF, OK);
    do_read(8'h2C, 32'h12345678, OK);
    do_write(8'h20, 32'h0, 4'hF, 8'h00, ERR);
    do_read(8'h20, 32'hDEADBEEF, OK);
    chk("ro_write_no_side_effect", {32'd0, rw_regs[31:0]}, 64'h1);
    do_write(8'h40, 32'hFFFFFFFF, 4'hF, 8'h00, ERR);
    do_read(8'h30, 32'h0, ERR);
    do_read(8'h40, 32'h0, ERR);

    // Same-edge write and read of register 2
    do_write(8'h08, 32'h5, 4'hF, 8'h04, OK);
    S_AXI_AWADDR = 8'h08; S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 8'h08;
    bq.push_back(OK); pq.push_back(8'h04); rq.push_back({32'h5, OK});
    hs(1, 1, 1, cyc);
    chk("concurrent_same_cycle", 64'(cyc), 1);
    @(negedge clk); chk("concurrent_valids", {62'd0, S_AXI_BVALID, S_AXI_RVALID}, 64'h3);
    @(posedge clk); #1;
    do_read(8'h08, 32'h9, OK);

    // Reset with AW held and W pending
    S_AXI_AWADDR = 8'h18;
    hs(1, 0, 0, cyc);
    @(negedge clk); chk("midwr_no_b", {63'd0, S_AXI_BVALID}, 0);
    #2 ARESETN = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("midwr_reg6", {32'd0, rw_regs[6*32 +: 32]}, 0);
    chk("midwr_rst_ready", {62'd0, S_AXI_AWREADY, S_AXI_BVALID}, 0);
    ARESETN = 1;
    repeat (3) begin @(negedge clk); chk("postrst_no_b", {63'd0, S_AXI_BVALID}, 0); end
    @(posedge clk); #1;
    do_write(8'h18, 32'h66, 4'hF, 8'h40, OK);
    do_read(8'h18, 32'h66, OK);
    do_read(8'h00, 32'h0, OK);

    repeat (3) @(posedge clk);
    chk("bq_drained", 64'(bq.size()), 0);
    chk("rq_drained", 64'(rq.size()), 0);
    chk("pq_drained", 64'(pq.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/rsa_axil_regbank.md
Name: rsa_axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 4-register S00_AXI slave in rsa_accelerator_v1_0.
- Provides NUM_RW read/write control registers (key_n, key_e, command) and NUM_RO read-only status registers fed from the RSA core.
- Adds byte-strobe writes, independent AW/W capture, per-register write pulses and address-range error responses.
- Sits between the AXI interconnect (or the VIP master in bench) and the rsa_core control/status signals.

Parameters:
- C_DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- C_ADDR_WIDTH, 8, AXI byte-address width.
- NUM_RW, 8, number of read/write registers; range 1..32.
- NUM_RO, 4, number of read-only registers; range 0..16; NUM_RW+NUM_RO <= 2^(C_ADDR_WIDTH-ALSB).
- RW_RESET, 0, reset value of every RW register.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  C_DATA_WIDTH; S_AXI_WSTRB  in  C_DATA_WIDTH/8; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  C_ADDR_WIDTH; S_AXI_ARPROT  in  3 (ignored); S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  C_DATA_WIDTH; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- rw_regs  out  NUM_RW*C_DATA_WIDTH  flattened RW register contents; reg i at [i*W +: W].
- wr_pulse  out  NUM_RW  one-cycle strobe per RW register, asserted the cycle after that register is written.
- ro_in  in  NUM_RO*C_DATA_WIDTH  status values; sampled combinationally at AR handshake.

Behaviour:
- ALSB = 2 for 32-bit, 3 for 64-bit. Register index idx = addr[C_ADDR_WIDTH-1:ALSB]; low address bits ignored.
- Decode:
  - idx < NUM_RW: RW register.
  - NUM_RW <= idx < NUM_RW+NUM_RO: RO register (ro_in[idx-NUM_RW]).
  - Otherwise: unmapped.
- Reset (asynchronous, ARESETN=0):
  - All RW registers = RW_RESET.
  - All READY/VALID outputs 0; BRESP/RRESP = 0; RDATA = 0; wr_pulse = 0.
  - Internal AW/W holding flags cleared.
  - Reset mid-transaction drops the transaction; no B/R response is issued afterwards.
- Write channel FSM, states W_IDLE and W_RESP:
  - W_IDLE: AWREADY=1 while no address is held; WREADY=1 while no data is held. AW and W may arrive in either order or in the same cycle; each is latched independently.
  - When both are held, the write commits on that edge: each byte lane k with WSTRB[k]=1 is updated. Transition to W_RESP with BVALID=1 on the next cycle; latency from the later of AW/W handshake to BVALID is 1 cycle.
  - W_RESP: AWREADY=WREADY=0; BVALID held until BREADY; return to W_IDLE and clear the holding flags.
  - Back-to-back writes: minimum 2 cycles per write when BREADY is tied high.
  - Writes to RO or unmapped registers modify nothing and produce no wr_pulse.
  - WSTRB=0 to an RW register: no change, but wr_pulse still fires, BRESP=OKAY.
- Read channel FSM, states R_IDLE and R_DATA:
  - R_IDLE: ARREADY=1. On handshake, RDATA/RRESP are registered and RVALID=1 next cycle.
  - R_DATA: ARREADY=0; RDATA stable until RREADY; then return to R_IDLE.
  - Unmapped reads return RDATA=0.
- Simultaneous read and write commit to the same RW register in one cycle: read returns the pre-write value.
- Read and write FSMs are fully independent; neither stalls the other.

Optional Feature:
- Macro: RSA_REGBANK_SLVERR_EN.
- Defined: write to RO or unmapped address gives BRESP=2'b10 (SLVERR); read from unmapped address gives RRESP=2'b10 with RDATA=0.
- Undefined: all responses are OKAY (2'b00); side effects are unchanged (writes ignored, reads return 0).

Test Plan:
- Reset: ARESETN low 100 ns, then write 0x1,0x2,0x3,0x4 to 0x00..0x0C and read back -> each BRESP=OKAY; reads return 0x1..0x4; wr_pulse[0..3] fire once each.
- Byte strobes: write 0xAABBCCDD to 0x04, then 0x11223344 with WSTRB=4'b0101 -> read 0x04 returns 0xAA22CC44.
- Channel ordering: W presented 3 cycles before AW, then AW 2 cycles before W -> both commit; BVALID asserts exactly 1 cycle after the later handshake; BREADY held low 5 cycles keeps BVALID and BRESP stable.
- RO / unmapped (NUM_RW=8, NUM_RO=4): ro_in[0]=0xDEADBEEF, read 0x20 -> 0xDEADBEEF; write 0x20 -> ro unchanged. Read 0x40 -> RDATA=0, RRESP=SLVERR with macro, OKAY without.
- Concurrency: reg 2 holds 0x5; in the same cycle write 0x9 to 0x08 and AR 0x08 -> read returns 0x5, a following read returns 0x9.
- Reset mid-write: AW accepted, W pending, assert ARESETN low -> BVALID stays 0, register keeps RW_RESET, the next full write completes normally.
